player_pos_validator: RTL and testbench

Responder to the player motion block's position-validity query. It takes a proposed top-left player position, checks the 32x32 hitbox against the board bounds, the fixed pillar grid and the tile map, and returns a registered valid/blocked verdict with a one-cycle done pulse. It sits between player motion and the tile-map RAM and drives valid_player_pos.

---
 rtl/player_pos_validator_if.sv | 26 ++
 rtl/player_pos_validator.sv | 141 ++++++++++++++
 tb/tb_player_pos_validator.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/player_pos_validator_if.sv
// Query/verdict handshake between player motion and the validator,
// plus the tile-map read port the validator drives.
`timescale 1ns/1ps
interface player_pos_validator_if;
  logic               req;
  logic signed [10:0] reqX;
  logic signed [10:0] reqY;
  logic               pass_bomb;
  logic               tile_rd;
  logic [4:0]         tile_col;
  logic [3:0]         tile_row;
  logic [1:0]         tile_type;
  logic               busy;
  logic               done;
  logic               valid_player_pos;

  modport master (
    output req, reqX, reqY, pass_bomb, tile_type,
    input  tile_rd, tile_col, tile_row, busy, done, valid_player_pos
  );

  modport slave (
    input  req, reqX, reqY, pass_bomb, tile_type,
    output tile_rd, tile_col, tile_row, busy, done, valid_player_pos
  );
endinterface

// File: rtl/player_pos_validator.sv
// Checks a proposed 32x32 player position against board bounds, pillars and
// the tile map; returns a registered verdict with a one-cycle done pulse.
`timescale 1ns/1ps
module player_pos_validator #(
  parameter int BOARD_LEFT = 15,
  parameter int BOARD_TOP  = 48,
  parameter int TILE_SIZE  = 32,
  parameter int COLS       = 19,
  parameter int ROWS       = 13,
  parameter int OBJ_W      = 32,
  parameter int OBJ_H      = 32,
  parameter int MARGIN     = 2
) (
  input logic                   clk,
  input logic                   resetN,
  player_pos_validator_if.slave bus
);

  localparam int SHIFT = $clog2(TILE_SIZE);
  localparam logic signed [12:0] X_LO = 13'(BOARD_LEFT);
  localparam logic signed [12:0] Y_LO = 13'(BOARD_TOP);
  localparam logic signed [12:0] X_HI = 13'(BOARD_LEFT + COLS * TILE_SIZE - OBJ_W);
  localparam logic signed [12:0] Y_HI = 13'(BOARD_TOP + ROWS * TILE_SIZE - OBJ_H);

  typedef enum logic [2:0] {IDLE_ST, BOUNDS_ST, READ_ST, EVAL_ST, DONE_ST} state_t;

  state_t             state, state_n;
  logic signed [12:0] x_q, y_q, x_n, y_n;
  logic [1:0]         corner_q, corner_n;
  logic               busy_q, busy_n, done_q, done_n, rd_q, rd_n, valid_q, valid_n;
  logic [4:0]         col_q, col_n;
  logic [3:0]         row_q, row_n;

  logic [1:0]         addr_corner;
  logic signed [12:0] cx, cy;
  logic [4:0]         col_calc;
  logic [3:0]         row_calc;
  logic               oob, blocked;

  // Address is computed for the corner about to be read: 0 out of BOUNDS, corner+1 out of EVAL.
  always_comb begin
    addr_corner = (state == EVAL_ST) ? corner_q + 2'd1 : 2'd0;
    cx = addr_corner[0] ? x_q + 13'(OBJ_W - 1 - MARGIN) : x_q + 13'(MARGIN);
    cy = addr_corner[1] ? y_q + 13'(OBJ_H - 1 - MARGIN) : y_q + 13'(MARGIN);
    col_calc = 5'((cx - X_LO) >> SHIFT);
    row_calc = 4'((cy - Y_LO) >> SHIFT);
  end

  assign oob     = (x_q < X_LO) || (x_q > X_HI) || (y_q < Y_LO) || (y_q > Y_HI);
  assign blocked = (col_q[0] & row_q[0]) ||
                   (bus.tile_type == 2'd1) || (bus.tile_type == 2'd2) ||
                   ((bus.tile_type == 2'd3) && !bus.pass_bomb);

  always_comb begin
    state_n  = state;
    x_n      = x_q;
    y_n      = y_q;
    corner_n = corner_q;
    busy_n   = busy_q;
    done_n   = 1'b0;
    rd_n     = 1'b0;
    col_n    = col_q;
    row_n    = row_q;
    valid_n  = valid_q;
    unique case (state)
      IDLE_ST: begin
        if (bus.req) begin
          x_n     = {{2{bus.reqX[10]}}, bus.reqX};
          y_n     = {{2{bus.reqY[10]}}, bus.reqY};
          busy_n  = 1'b1;
          state_n = BOUNDS_ST;
        end
      end
      BOUNDS_ST: begin
        if (oob) begin
          valid_n = 1'b0;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = DONE_ST;
        end else begin
          corner_n = 2'd0;
          rd_n     = 1'b1;
          col_n    = col_calc;
          row_n    = row_calc;
          state_n  = READ_ST;
        end
      end
      READ_ST: state_n = EVAL_ST;
      EVAL_ST: begin
        if (blocked || corner_q == 2'd3) begin
          valid_n = !blocked;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = DONE_ST;
        end else begin
          corner_n = corner_q + 2'd1;
          rd_n     = 1'b1;
          col_n    = col_calc;
          row_n    = row_calc;
          state_n  = READ_ST;
        end
      end
      DONE_ST: state_n = IDLE_ST;
      default: state_n = IDLE_ST;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state    <= IDLE_ST;
      x_q      <= '0;
      y_q      <= '0;
      corner_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_q     <= 1'b0;
      col_q    <= '0;
      row_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      state    <= state_n;
      x_q      <= x_n;
      y_q      <= y_n;
      corner_q <= corner_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
      rd_q     <= rd_n;
      col_q    <= col_n;
      row_q    <= row_n;
      valid_q  <= valid_n;
    end
  end

  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.tile_rd          = rd_q;
  assign bus.tile_col         = col_q;
  assign bus.tile_row         = row_q;
  assign bus.valid_player_pos = valid_q;

endmodule

// File: tb/tb_player_pos_validator.sv
// Directed bench for player_pos_validator with a behavioural tile-map RAM.
`timescale 1ns/1ps
module tb_player_pos_validator;
  logic clk = 1'b0;
  logic resetN;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  player_pos_validator_if bus ();

  player_pos_validator #(
    .BOARD_LEFT(15), .BOARD_TOP(48), .TILE_SIZE(32), .COLS(19),
    .ROWS(13), .OBJ_W(32), .OBJ_H(32), .MARGIN(2)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0] map [0:12][0:18];

  // Tile data appears the cycle after the read strobe.
  always @(posedge clk or negedge resetN) begin
    if (!resetN) bus.tile_type <= 2'd0;
    else if (bus.tile_rd) bus.tile_type <= map[bus.tile_row][bus.tile_col];
  end

  int   q_lat, q_nrd, q_ndone;
  logic q_v, q_hold, q_busy1;
  int   rd_col [0:7];
  int   rd_row [0:7];

  task automatic clear_map();
    for (int r = 0; r < 13; r++)
      for (int c = 0; c < 19; c++)
        map[r][c] = 2'd0;
  endtask

  // Issues one query and watches 20 cycles; extra_at re-pulses req with an out-of-bounds X.
  task automatic run_query(input int x, input int y, input int extra_at);
    int n;
    q_nrd = 0; q_ndone = 0; q_lat = -1; q_v = 1'bx; q_busy1 = 1'b0;
    @(negedge clk);
    n = cyc;
    bus.req = 1'b1; bus.reqX = 11'(x); bus.reqY = 11'(y);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      bus.req = (i == extra_at);
      if (i == extra_at) bus.reqX = 11'(14);
      if (i == 1) q_busy1 = bus.busy;
      if (bus.tile_rd) begin
        if (q_nrd < 8) begin
          rd_col[q_nrd] = int'(bus.tile_col);
          rd_row[q_nrd] = int'(bus.tile_row);
        end
        q_nrd++;
      end
      if (bus.done) begin
        q_ndone++;
        if (q_lat < 0) begin
          q_lat = cyc - n;
          q_v = bus.valid_player_pos;
        end
      end
    end
    q_hold = bus.valid_player_pos;
  endtask

  task automatic test_reset();
    int nd;
    resetN = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.valid_player_pos, bus.done, bus.busy, bus.tile_rd, bus.tile_col, bus.tile_row} !== 13'd0) begin
      errors++;
      $display("FAIL reset_state: got %b required 0", {bus.valid_player_pos, bus.done, bus.busy, bus.tile_rd, bus.tile_col, bus.tile_row});
    end
    resetN = 1'b1;
    @(negedge clk);
    bus.req = 1'b1; bus.reqX = 11'(47); bus.reqY = 11'(48);
    @(negedge clk);
    bus.req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.tile_rd !== 1'b1 || bus.tile_col !== 5'd1 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_read: rd=%b col=%0d busy=%b required rd=1 col=1 busy=1", bus.tile_rd, bus.tile_col, bus.busy);
    end
    resetN = 1'b0;
    #1;
    checks++;
    if ({bus.valid_player_pos, bus.done, bus.busy, bus.tile_rd, bus.tile_col, bus.tile_row} !== 13'd0) begin
      errors++;
      $display("FAIL midread_reset: got %b required 0", {bus.valid_player_pos, bus.done, bus.busy, bus.tile_rd, bus.tile_col, bus.tile_row});
    end
    @(negedge clk);
    resetN = 1'b1;
    nd = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    checks++;
    if (nd != 0) begin
      errors++;
      $display("FAIL discarded_query_done: got %0d dones required 0", nd);
    end
    run_query(47, 48, 0);
    checks++;
    if (q_lat != 10 || q_v !== 1'b1 || q_nrd != 4 || q_ndone != 1) begin
      errors++;
      $display("FAIL post_reset_query: lat=%0d v=%b rd=%0d dn=%0d required 10 1 4 1", q_lat, q_v, q_nrd, q_ndone);
    end
  endtask

  task automatic test_valid_origin();
    run_query(15, 48, 0);
    checks++;
    if (q_lat != 10 || q_v !== 1'b1 || q_ndone != 1) begin
      errors++;
      $display("FAIL origin_verdict: lat=%0d v=%b dn=%0d required 10 1 1", q_lat, q_v, q_ndone);
    end
    checks++;
    if (q_busy1 !== 1'b1) begin
      errors++;
      $display("FAIL origin_busy: got %b required 1", q_busy1);
    end
    checks++;
    if (q_nrd != 4) begin
      errors++;
      $display("FAIL origin_reads: got %0d required 4", q_nrd);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rd_col[k] != 0 || rd_row[k] != 0) begin
        errors++;
        $display("FAIL origin_addr%0d: got (%0d,%0d) required (0,0)", k, rd_col[k], rd_row[k]);
      end
    end
  endtask

  task automatic test_bounds();
    int xs [0:4] = '{14, 592, 15, 15, -5};
    int ys [0:4] = '{48, 48, 433, 47, 100};
    for (int k = 0; k < 5; k++) begin
      run_query(xs[k], ys[k], 0);
      checks++;
      if (q_lat != 2 || q_v !== 1'b0 || q_nrd != 0 || q_ndone != 1) begin
        errors++;
        $display("FAIL oob_%0d: lat=%0d v=%b rd=%0d dn=%0d required 2 0 0 1", k, q_lat, q_v, q_nrd, q_ndone);
      end
    end
    run_query(591, 432, 0);
    checks++;
    if (q_lat != 10 || q_v !== 1'b1 || q_nrd != 4 || rd_col[3] != 18 || rd_row[3] != 12) begin
      errors++;
      $display("FAIL max_inbounds: lat=%0d v=%b rd=%0d addr=(%0d,%0d) required 10 1 4 (18,12)", q_lat, q_v, q_nrd, rd_col[3], rd_row[3]);
    end
  endtask

  task automatic test_pillar();
    int ec [0:3] = '{0, 1, 0, 1};
    int er [0:3] = '{0, 0, 1, 1};
    run_query(40, 70, 0);
    checks++;
    if (q_lat != 10 || q_v !== 1'b0 || q_nrd != 4) begin
      errors++;
      $display("FAIL pillar_verdict: lat=%0d v=%b rd=%0d required 10 0 4", q_lat, q_v, q_nrd);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rd_col[k] != ec[k] || rd_row[k] != er[k]) begin
        errors++;
        $display("FAIL pillar_addr%0d: got (%0d,%0d) required (%0d,%0d)", k, rd_col[k], rd_row[k], ec[k], er[k]);
      end
    end
  endtask

  task automatic test_tiles();
    map[0][1] = 2'd2;
    run_query(47, 48, 0);
    checks++;
    if (q_lat != 4 || q_v !== 1'b0 || q_nrd != 1) begin
      errors++;
      $display("FAIL brick: lat=%0d v=%b rd=%0d required 4 0 1", q_lat, q_v, q_nrd);
    end
    map[0][1] = 2'd3;
    bus.pass_bomb = 1'b0;
    run_query(47, 48, 0);
    checks++;
    if (q_lat != 4 || q_v !== 1'b0 || q_nrd != 1) begin
      errors++;
      $display("FAIL bomb_block: lat=%0d v=%b rd=%0d required 4 0 1", q_lat, q_v, q_nrd);
    end
    bus.pass_bomb = 1'b1;
    run_query(47, 48, 0);
    checks++;
    if (q_lat != 10 || q_v !== 1'b1 || q_nrd != 4) begin
      errors++;
      $display("FAIL bomb_pass: lat=%0d v=%b rd=%0d required 10 1 4", q_lat, q_v, q_nrd);
    end
    bus.pass_bomb = 1'b0;
    clear_map();
  endtask

  task automatic test_back_to_back();
    run_query(40, 70, 3);
    checks++;
    if (q_ndone != 1 || q_lat != 10 || q_v !== 1'b0) begin
      errors++;
      $display("FAIL busy_req_ignored: dn=%0d lat=%0d v=%b required 1 10 0", q_ndone, q_lat, q_v);
    end
    checks++;
    if (q_hold !== 1'b0) begin
      errors++;
      $display("FAIL verdict_hold: got %b required 0", q_hold);
    end
    run_query(15, 48, 0);
    checks++;
    if (q_hold !== 1'b1 || q_v !== 1'b1) begin
      errors++;
      $display("FAIL verdict_hold_valid: hold=%b v=%b required 1 1", q_hold, q_v);
    end
  endtask

  initial begin
    bus.req = 1'b0; bus.reqX = '0; bus.reqY = '0; bus.pass_bomb = 1'b0;
    clear_map();
    test_reset();
    test_valid_origin();
    test_bounds();
    test_pillar();
    test_tiles();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
